skid_pipe_reg: RTL

SKID_PIPE_REG -- requirements
Module: skid_pipe_reg

---
 rtl/skid_pipe_reg.sv | 106 ++++++++++
 1 files changed

// File: rtl/skid_pipe_reg.sv
// Two-entry elastic pipeline stage (main + skid register) with valid/ready handshakes.
// in_ready comes from registered state only, so there is no combinational path from out_ready.
module skid_pipe_reg #(
   parameter int unsigned      WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       count
);

   // The state encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] main_p0;
   logic [WIDTH-1:0] skid_p0;
   logic             in_fire;
   logic             out_fire;
   logic             load_main;
   logic             load_skid;
   logic             main_from_skid;

   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   assign out_data  = main_p0;
   assign count     = state_q;

   always_comb begin
      state_d        = state_q;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
      case (state_q)
         EMPTY: begin
            if (in_fire) begin
               load_main = 1'b1;
               state_d   = BUSY;
            end
         end
         BUSY: begin
            if (in_fire && out_fire) begin
               load_main = 1'b1;
            end else if (in_fire) begin
               load_skid = 1'b1;
               state_d   = FULL;
            end else if (out_fire) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (out_fire) begin
               load_main      = 1'b1;
               main_from_skid = 1'b1;
               state_d        = BUSY;
            end
         end
         default: state_d = EMPTY;
      endcase
      // Flush empties the stage but leaves both data registers untouched.
      if (flush) begin
         state_d        = EMPTY;
         load_main      = 1'b0;
         load_skid      = 1'b0;
         main_from_skid = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Stage p0: head and skid storage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_p0 <= RESET_VALUE;
         skid_p0 <= RESET_VALUE;
      end else begin
         if (load_main) begin
            main_p0 <= main_from_skid ? skid_p0 : in_data;
         end
         if (load_skid) begin
            skid_p0 <= in_data;
         end
      end
   end

endmodule
